// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the hardwired control unit of the 32-bit bus CPU:
// opcode constants, bus-source codes, ALU op codes, the sequencer state enum,
// the opcode class enum, and one-hot/index helper functions.
// ---------------------------------------------------------------------------
package cpu_pkg;

  // Opcodes (IR[31:27])
  localparam logic [4:0] OP_LD    = 5'b00000;
  localparam logic [4:0] OP_LDI   = 5'b00001;
  localparam logic [4:0] OP_ST    = 5'b00010;
  localparam logic [4:0] OP_RT_LO = 5'b00011;  // first R-type opcode
  localparam logic [4:0] OP_RT_HI = 5'b01010;  // last R-type opcode
  localparam logic [4:0] OP_ADDI  = 5'b01011;
  localparam logic [4:0] OP_BR    = 5'b10010;
  localparam logic [4:0] OP_NOP   = 5'b11000;
  localparam logic [4:0] OP_HALT  = 5'b11010;

  // Bus source codes (0-15 select R0-R15 directly)
  localparam logic [4:0] SEL_HI     = 5'd16;
  localparam logic [4:0] SEL_LO     = 5'd17;
  localparam logic [4:0] SEL_ZHI    = 5'd18;
  localparam logic [4:0] SEL_ZLO    = 5'd19;
  localparam logic [4:0] SEL_PC     = 5'd20;
  localparam logic [4:0] SEL_MDR    = 5'd21;
  localparam logic [4:0] SEL_INPORT = 5'd22;
  localparam logic [4:0] SEL_CSIGN  = 5'd23;

  // ALU op codes
  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_IMM     = 3'd1,  // addi and ldi share one sequence
    CLS_LD      = 3'd2,
    CLS_ST      = 3'd3,
    CLS_BR      = 3'd4,
    CLS_NOP     = 3'd5,
    CLS_HALT    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } op_class_t;

  // 4-to-16 one-hot decode
  function automatic logic [15:0] idx_to_oh16(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

  // 16-to-4 encode of a one-hot register select
  function automatic logic [3:0] oh16_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) begin
        idx = idx | 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ir_decode.sv
// ---------------------------------------------------------------------------
// ir_decode
// Splits the instruction register into its fields, produces one-hot register
// selects for Ra, Rb and Rc, and classifies the opcode into the sequence the
// control FSM must run.
// Ports:
//   ir_i        instruction register contents
//   opcode_o    IR[31:27]
//   ra_oh_o     one-hot of Ra (IR[26:23])
//   rb_oh_o     one-hot of Rb (IR[22:19])
//   rc_oh_o     one-hot of Rc (IR[18:15])
//   op_class_o  instruction class
// ---------------------------------------------------------------------------
module ir_decode
  import cpu_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [4:0]  opcode_o,
  output logic [15:0] ra_oh_o,
  output logic [15:0] rb_oh_o,
  output logic [15:0] rc_oh_o,
  output op_class_t   op_class_o
);

  // The low part of the C constant is consumed by the datapath sign extender,
  // not by the control unit.
  logic unused_c_low_s;
  assign unused_c_low_s = ^ir_i[14:0];

  assign opcode_o = ir_i[31:27];
  assign ra_oh_o  = idx_to_oh16(ir_i[26:23]);
  assign rb_oh_o  = idx_to_oh16(ir_i[22:19]);
  assign rc_oh_o  = idx_to_oh16(ir_i[18:15]);

  // Opcode classification; anything not listed is undecoded
  always_comb begin
    op_class_o = CLS_ILLEGAL;
    if ((opcode_o >= OP_RT_LO) && (opcode_o <= OP_RT_HI)) begin
      op_class_o = CLS_RTYPE;
    end else begin
      case (opcode_o)
        OP_LD:           op_class_o = CLS_LD;
        OP_LDI, OP_ADDI: op_class_o = CLS_IMM;
        OP_ST:           op_class_o = CLS_ST;
        OP_BR:           op_class_o = CLS_BR;
        OP_NOP:          op_class_o = CLS_NOP;
        OP_HALT:         op_class_o = CLS_HALT;
        default:         op_class_o = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
// Hardwired control unit: steps each instruction through fetch (T0-T2) and
// execute (T3-T7) T-states, driving register strobes, bus select, ALU op and
// the memory handshake. Outputs are a combinational decode of the registered
// state and the IR fields; memory waits stretch T1, ld-T6 and st-T7.
// Ports:
//   clk, clr              clock, synchronous active-high reset
//   ir                    instruction register contents
//   con_ff                branch condition from the datapath
//   mem_ack               memory read valid / write complete
//   gp_in                 one-hot load enable R0-R15
//   bus_sel               bus source select
//   pc_in..con_in         register load strobes
//   inc_pc, alu_op        ALU control
//   mdr_read              MDR input mux (1 = memory)
//   mem_rd, mem_wr        memory requests
//   run                   high in T0-T7
//   illegal               sticky illegal-opcode flag
// Build option: CTRL_ILLEGAL_TRAP_EN - undecoded opcodes set illegal and halt;
// when undefined they behave as nop and illegal is tied low.
// ---------------------------------------------------------------------------
module ctrl_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ack,
  output logic [15:0] gp_in,
  output logic [4:0]  bus_sel,
  output logic        pc_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        con_in,
  output logic        inc_pc,
  output logic [4:0]  alu_op,
  output logic        mdr_read,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        run,
  output logic        illegal
);

  state_t      state_q, state_d;
  logic        t1_wait_q, t1_wait_d;  // set while T1 is being repeated
  logic [4:0]  opcode_s;
  logic [15:0] ra_oh_s, rb_oh_s, rc_oh_s;
  op_class_t   op_class_s;
  logic [4:0]  ra_sel_s, rb_sel_s, rc_sel_s;

  ir_decode u_ir_decode (
    .ir_i       (ir),
    .opcode_o   (opcode_s),
    .ra_oh_o    (ra_oh_s),
    .rb_oh_o    (rb_oh_s),
    .rc_oh_o    (rc_oh_s),
    .op_class_o (op_class_s)
  );

  // Register bus codes 0-15 equal the register index
  assign ra_sel_s = {1'b0, oh16_to_idx(ra_oh_s)};
  assign rb_sel_s = {1'b0, oh16_to_idx(rb_oh_s)};
  assign rc_sel_s = {1'b0, oh16_to_idx(rc_oh_s)};

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | ((state_q == ST_T2) && (op_class_s == CLS_ILLEGAL));

  // Sticky illegal flag, cleared only by clr
  always_ff @(posedge clk) begin
    if (clr) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`else
  localparam logic TRAP_EN = 1'b0;
  assign illegal = 1'b0;
`endif

  // A wait in T1 is any T1 cycle without acknowledge; the next cycle is a repeat
  assign t1_wait_d = (state_q == ST_T1) && !mem_ack;

  // State register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_RESET;
      t1_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t1_wait_q <= t1_wait_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0:    state_d = ST_T1;
      ST_T1:    state_d = mem_ack ? ST_T2 : ST_T1;
      ST_T2: begin
        case (op_class_s)
          CLS_NOP:     state_d = ST_T0;
          CLS_HALT:    state_d = ST_HALT;
          CLS_ILLEGAL: state_d = TRAP_EN ? ST_HALT : ST_T0;
          default:     state_d = ST_T3;
        endcase
      end
      ST_T3: state_d = ST_T4;
      ST_T4: state_d = ST_T5;
      ST_T5: begin
        case (op_class_s)
          CLS_LD, CLS_ST, CLS_BR: state_d = ST_T6;
          default:                state_d = ST_T0;
        endcase
      end
      ST_T6: begin
        case (op_class_s)
          CLS_LD:  state_d = mem_ack ? ST_T7 : ST_T6;
          CLS_ST:  state_d = ST_T7;
          default: state_d = ST_T0;
        endcase
      end
      ST_T7: begin
        case (op_class_s)
          CLS_ST:  state_d = mem_ack ? ST_T0 : ST_T7;
          default: state_d = ST_T0;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RESET;
    endcase
  end

  // Output decode of state and IR fields
  always_comb begin
    gp_in    = 16'h0000;
    bus_sel  = 5'd0;
    pc_in    = 1'b0;
    ir_in    = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    mar_in   = 1'b0;
    mdr_in   = 1'b0;
    con_in   = 1'b0;
    inc_pc   = 1'b0;
    mdr_read = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    if ((state_q == ST_RESET) || (state_q == ST_HALT)) begin
      run    = 1'b0;
      alu_op = ALU_NONE;
    end else begin
      run    = 1'b1;
      alu_op = ALU_ADD;
    end
    case (state_q)
      ST_T0: begin
        bus_sel = SEL_PC;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        z_in    = 1'b1;
      end
      ST_T1: begin
        bus_sel  = SEL_ZLO;
        pc_in    = !t1_wait_q;  // PC loads once per fetch, however long the wait
        mem_rd   = 1'b1;
        mdr_read = 1'b1;
        mdr_in   = mem_ack;
      end
      ST_T2: begin
        bus_sel = SEL_MDR;
        ir_in   = 1'b1;
      end
      ST_T3: begin
        case (op_class_s)
          CLS_BR: begin
            bus_sel = ra_sel_s;
            con_in  = 1'b1;
          end
          CLS_RTYPE, CLS_IMM, CLS_LD, CLS_ST: begin
            bus_sel = rb_sel_s;
            y_in    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (op_class_s)
          CLS_BR: begin
            bus_sel = SEL_PC;
            y_in    = 1'b1;
          end
          CLS_RTYPE: begin
            bus_sel = rc_sel_s;
            alu_op  = opcode_s;
            z_in    = 1'b1;
          end
          CLS_IMM, CLS_LD, CLS_ST: begin
            bus_sel = SEL_CSIGN;
            z_in    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (op_class_s)
          CLS_RTYPE, CLS_IMM: begin
            bus_sel = SEL_ZLO;
            gp_in   = ra_oh_s;
          end
          CLS_LD, CLS_ST: begin
            bus_sel = SEL_ZLO;
            mar_in  = 1'b1;
          end
          CLS_BR: begin
            bus_sel = SEL_CSIGN;
            z_in    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        case (op_class_s)
          CLS_LD: begin
            mem_rd   = 1'b1;
            mdr_read = 1'b1;
            mdr_in   = mem_ack;
          end
          CLS_ST: begin
            bus_sel = ra_sel_s;
            mdr_in  = 1'b1;
          end
          CLS_BR: begin
            if (con_ff) begin
              bus_sel = SEL_ZLO;
              pc_in   = 1'b1;
            end else begin
              pc_in   = 1'b0;
            end
          end
          default: ;
        endcase
      end
      ST_T7: begin
        case (op_class_s)
          CLS_LD: begin
            bus_sel = SEL_MDR;
            gp_in   = ra_oh_s;
          end
          CLS_ST: mem_wr = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
